// File: rtl/stream_demux_n.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// stream_demux_n
//
// Registered 1-to-NUM_CH stream demultiplexer with valid/ready handshakes.
// Each accepted input word is routed to one output channel, which holds it in
// a one-entry register until that channel's consumer takes it.
//   MODE 0 : the target channel is in_sel; a target >= NUM_CH is dropped and
//            counted (drop_err pulses, drop_cnt saturates).
//   MODE 1 : the target channel is a round-robin pointer. It advances only
//            when a word is accepted, so a stalled channel holds the rotation.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   producer word valid
//   in_ready   block can accept a word this cycle (independent of in_valid)
//   in_data    producer word, WIDTH bits
//   in_sel     target channel (MODE 0 only), SEL_W bits
//   out_valid  per-channel valid, bit i is channel i
//   out_ready  per-channel consumer ready
//   out_data   channel i occupies bits [i*WIDTH +: WIDTH]
//   drop_err   one-cycle pulse after an out-of-range word is dropped
//   drop_cnt   saturating count of dropped words
// ---------------------------------------------------------------------------
module stream_demux_n #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int MODE   = 0,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    output logic [NUM_CH-1:0]         out_valid,
    input  logic [NUM_CH-1:0]         out_ready,
    output logic [NUM_CH*WIDTH-1:0]   out_data,
    output logic                      drop_err,
    output logic [CNT_W-1:0]          drop_cnt
);

    // One extra bit so NUM_CH == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0]   LP_NUM_CH  = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LP_LAST_CH = SEL_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

    logic [SEL_W-1:0]             r_rr_ptr;
    logic [NUM_CH-1:0]            r_valid;
    logic [NUM_CH-1:0][WIDTH-1:0] r_data;
    logic                         r_drop_err;
    logic [CNT_W-1:0]             r_drop_cnt;

    logic [SEL_W-1:0]             w_tgt;
    logic                         w_in_range;
    logic                         w_slot_free;
    logic                         w_in_ready;
    logic                         w_accept;
    logic                         w_drop;
    logic [NUM_CH-1:0]            w_load;
    logic                         w_unused_sel;

    // in_sel is ignored in round-robin mode.
    assign w_unused_sel = (MODE == 1) ? ^in_sel : 1'b0;

    assign w_tgt      = (MODE == 1) ? r_rr_ptr : in_sel;
    assign w_in_range = ({1'b0, w_tgt} < LP_NUM_CH);

    // Target slot can take a word if empty, or if it drains this same edge.
    always_comb begin
        w_slot_free = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_tgt == SEL_W'(i)) begin
                w_slot_free = !r_valid[i] || out_ready[i];
            end
        end
    end

    // Out-of-range words are always accepted so they can be discarded.
    assign w_in_ready = !w_in_range || w_slot_free;
    assign w_accept   = in_valid && w_in_ready;
    assign w_drop     = w_accept && !w_in_range;

    always_comb begin
        w_load = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_load[i] = w_accept && w_in_range && (w_tgt == SEL_W'(i));
        end
    end

    // Per-channel holding registers: a load wins over a drain, giving one
    // word per cycle per channel with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (w_load[i]) begin
                    r_data[i]  <= in_data;
                    r_valid[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if ((MODE == 1) && w_accept) begin
            r_rr_ptr <= (r_rr_ptr == LP_LAST_CH) ? '0 : r_rr_ptr + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_err <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_drop_err <= w_drop;
            if (w_drop && (r_drop_cnt != LP_CNT_MAX)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign drop_err  = r_drop_err;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_stream_demux_n.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_stream_demux_n
//
// Three instances share the producer/consumer stimulus:
//   u_dut0 : MODE 0, NUM_CH 4
//   u_dut1 : MODE 1, NUM_CH 4
//   u_dut2 : MODE 0, NUM_CH 3 (in_sel 3 is out of range)
// Each task looks only at the instance it is about; the others see the same
// inputs and are ignored. Inputs change 1 ns after a rising edge, outputs are
// sampled 4 ns after it.
// ---------------------------------------------------------------------------
module tb_stream_demux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic [3:0] out_ready;

    logic        r0, r1, r2;
    logic [3:0]  v0, v1;
    logic [2:0]  v2;
    logic [31:0] d0, d1;
    logic [23:0] d2;
    logic        e0, e1, e2;
    logic [7:0]  c0, c1, c2;

    int n_chk  = 0;
    int n_fail = 0;

    // Selected-instance view for the generic tasks.
    int          dsel = 0;
    logic        c_rdy;
    logic [3:0]  c_val;
    logic [31:0] c_dat;
    logic        c_err;
    logic [7:0]  c_cnt;

    stream_demux_n #(.WIDTH(8), .NUM_CH(4), .SEL_W(2), .MODE(0), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0), .in_data(in_data),
        .in_sel(in_sel), .out_valid(v0), .out_ready(out_ready), .out_data(d0),
        .drop_err(e0), .drop_cnt(c0));

    stream_demux_n #(.WIDTH(8), .NUM_CH(4), .SEL_W(2), .MODE(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
        .in_sel(in_sel), .out_valid(v1), .out_ready(out_ready), .out_data(d1),
        .drop_err(e1), .drop_cnt(c1));

    stream_demux_n #(.WIDTH(8), .NUM_CH(3), .SEL_W(2), .MODE(0), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2), .in_data(in_data),
        .in_sel(in_sel), .out_valid(v2), .out_ready(out_ready[2:0]), .out_data(d2),
        .drop_err(e2), .drop_cnt(c2));

    always_comb begin
        case (dsel)
            0: begin
                c_rdy = r0; c_val = v0; c_dat = d0; c_err = e0; c_cnt = c0;
            end
            1: begin
                c_rdy = r1; c_val = v1; c_dat = d1; c_err = e1; c_cnt = c1;
            end
            default: begin
                c_rdy = r2; c_val = {1'b0, v2}; c_dat = {8'h00, d2}; c_err = e2; c_cnt = c2;
            end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        #2;
        rst      = 1'b0;
        tick();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            dsel = k;
            #1;
            n_chk++; if (c_val !== 4'b0000) begin n_fail++; $display("FAIL reset out_valid dut%0d: got %b expected 0000", k, c_val); end
            n_chk++; if (c_dat !== 32'h0) begin n_fail++; $display("FAIL reset out_data dut%0d: got %h expected 0", k, c_dat); end
            n_chk++; if (c_err !== 1'b0) begin n_fail++; $display("FAIL reset drop_err dut%0d: got %b expected 0", k, c_err); end
            n_chk++; if (c_cnt !== 8'd0) begin n_fail++; $display("FAIL reset drop_cnt dut%0d: got %0d expected 0", k, c_cnt); end
            n_chk++; if (c_rdy !== 1'b1) begin n_fail++; $display("FAIL reset in_ready dut%0d: got %b expected 1", k, c_rdy); end
        end
        rst = 1'b0;
        tick();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_addressed();
        logic [3:0] exp_v;
        apply_reset();
        out_ready = 4'hF;
        for (int k = 0; k < 5; k++) begin
            in_valid = (k < 4);
            in_data  = 8'(8'hA1 + k);
            in_sel   = 2'(k);
            #3;
            if (k < 4) begin
                n_chk++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL addr in_ready word %0d: got %b expected 1", k, r0); end
            end
            exp_v = (k == 0) ? 4'b0000 : 4'(4'b0001 << (k - 1));
            n_chk++; if (v0 !== exp_v) begin n_fail++; $display("FAIL addr out_valid cycle %0d: got %b expected %b", k, v0, exp_v); end
            if (k > 0) begin
                n_chk++; if (d0[(k-1)*8 +: 8] !== 8'(8'hA0 + k)) begin n_fail++; $display("FAIL addr out_data ch%0d: got %h expected %h", k - 1, d0[(k-1)*8 +: 8], 8'(8'hA0 + k)); end
            end
            tick();
        end
        #3;
        n_chk++; if (v0 !== 4'b0000) begin n_fail++; $display("FAIL addr drained out_valid: got %b expected 0000", v0); end
        tick();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_stall();
        apply_reset();
        out_ready = 4'b1011;
        in_valid  = 1'b1; in_data = 8'h55; in_sel = 2'd2;
        #3;
        n_chk++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL stall first in_ready: got %b expected 1", r0); end
        tick();
        in_data = 8'h66;
        for (int k = 0; k < 2; k++) begin
            #3;
            n_chk++; if (r0 !== 1'b0) begin n_fail++; $display("FAIL stall blocked in_ready cyc %0d: got %b expected 0", k, r0); end
            n_chk++; if (v0[2] !== 1'b1) begin n_fail++; $display("FAIL stall held out_valid[2] cyc %0d: got %b expected 1", k, v0[2]); end
            n_chk++; if (d0[23:16] !== 8'h55) begin n_fail++; $display("FAIL stall held data cyc %0d: got %h expected 55", k, d0[23:16]); end
            if (k == 0) tick();
        end
        out_ready[2] = 1'b1;
        #1;
        n_chk++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL stall release in_ready: got %b expected 1", r0); end
        tick();
        in_valid = 1'b0;
        #3;
        n_chk++; if (v0[2] !== 1'b1) begin n_fail++; $display("FAIL stall drain+load out_valid[2]: got %b expected 1", v0[2]); end
        n_chk++; if (d0[23:16] !== 8'h66) begin n_fail++; $display("FAIL stall new data: got %h expected 66", d0[23:16]); end
        tick();
        #3;
        n_chk++; if (v0[2] !== 1'b0) begin n_fail++; $display("FAIL stall final out_valid[2]: got %b expected 0", v0[2]); end
        tick();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_drop();
        int exp_cnt;
        apply_reset();
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        for (int k = 0; k < 300; k++) begin
            in_data = 8'(k);
            #3;
            exp_cnt = (k > 255) ? 255 : k;
            n_chk++; if (r2 !== 1'b1) begin n_fail++; $display("FAIL drop in_ready k=%0d: got %b expected 1", k, r2); end
            n_chk++; if (v2 !== 3'b000) begin n_fail++; $display("FAIL drop out_valid k=%0d: got %b expected 000", k, v2); end
            n_chk++; if (e2 !== (k > 0)) begin n_fail++; $display("FAIL drop drop_err k=%0d: got %b expected %b", k, e2, (k > 0)); end
            n_chk++; if (c2 !== 8'(exp_cnt)) begin n_fail++; $display("FAIL drop drop_cnt k=%0d: got %0d expected %0d", k, c2, exp_cnt); end
            tick();
        end
        in_valid = 1'b0;
        #3;
        n_chk++; if (e2 !== 1'b1) begin n_fail++; $display("FAIL drop last pulse: got %b expected 1", e2); end
        n_chk++; if (c2 !== 8'd255) begin n_fail++; $display("FAIL drop saturated: got %0d expected 255", c2); end
        tick();
        #3;
        n_chk++; if (e2 !== 1'b0) begin n_fail++; $display("FAIL drop pulse end: got %b expected 0", e2); end
        n_chk++; if (c2 !== 8'd255) begin n_fail++; $display("FAIL drop hold count: got %0d expected 255", c2); end
        tick();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_async_reset();
        logic [1:0] sels [3] = '{2'd0, 2'd1, 2'd3};
        apply_reset();
        out_ready = 4'h0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'(8'h31 + k); in_sel = sels[k];
            #3;
            n_chk++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL areset fill in_ready %0d: got %b expected 1", k, r0); end
            tick();
        end
        in_valid = 1'b0;
        #3;
        n_chk++; if (v0 !== 4'b1011) begin n_fail++; $display("FAIL areset pre out_valid: got %b expected 1011", v0); end
        n_chk++; if (v1 !== 4'b0111) begin n_fail++; $display("FAIL areset pre rr out_valid: got %b expected 0111", v1); end
        n_chk++; if (c2 !== 8'd1) begin n_fail++; $display("FAIL areset pre drop_cnt: got %0d expected 1", c2); end
        rst = 1'b1;
        #1;
        n_chk++; if (v0 !== 4'b0000) begin n_fail++; $display("FAIL areset out_valid: got %b expected 0000", v0); end
        n_chk++; if (d0 !== 32'h0) begin n_fail++; $display("FAIL areset out_data: got %h expected 0", d0); end
        n_chk++; if (v1 !== 4'b0000) begin n_fail++; $display("FAIL areset rr out_valid: got %b expected 0000", v1); end
        n_chk++; if (c2 !== 8'd0) begin n_fail++; $display("FAIL areset drop_cnt: got %0d expected 0", c2); end
        n_chk++; if (e2 !== 1'b0) begin n_fail++; $display("FAIL areset drop_err: got %b expected 0", e2); end
        #2;
        rst = 1'b0;
        tick();
        out_ready = 4'hF;
        in_valid = 1'b1; in_data = 8'h44;
        #3;
        n_chk++; if (r1 !== 1'b1) begin n_fail++; $display("FAIL areset post in_ready: got %b expected 1", r1); end
        tick();
        in_valid = 1'b0;
        #3;
        n_chk++; if (v1 !== 4'b0001) begin n_fail++; $display("FAIL areset post rr channel: got %b expected 0001", v1); end
        n_chk++; if (d1[7:0] !== 8'h44) begin n_fail++; $display("FAIL areset post rr data: got %h expected 44", d1[7:0]); end
        tick();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_round_robin();
        logic       iv   [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [7:0] dat  [9] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h14, 8'h14, 8'h15, 8'h00};
        logic [3:0] ory  [9] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hF};
        logic       erdy [9] = '{1, 1, 1, 1, 0, 0, 1, 1, 1};
        logic [3:0] ev   [9] = '{4'b0000, 4'b0001, 4'b0011, 4'b0101, 4'b1001,
                                 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        int         ech  [9] = '{0, 0, 1, 2, 3, 0, 0, 0, 1};
        logic [7:0] edat [9] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h10, 8'h14, 8'h15};
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            in_valid = iv[k]; in_data = dat[k]; out_ready = ory[k];
            #3;
            n_chk++; if (r1 !== erdy[k]) begin n_fail++; $display("FAIL rr in_ready cyc %0d: got %b expected %b", k, r1, erdy[k]); end
            n_chk++; if (v1 !== ev[k]) begin n_fail++; $display("FAIL rr out_valid cyc %0d: got %b expected %b", k, v1, ev[k]); end
            if (k > 0) begin
                n_chk++; if (d1[ech[k]*8 +: 8] !== edat[k]) begin n_fail++; $display("FAIL rr data ch%0d cyc %0d: got %h expected %h", ech[k], k, d1[ech[k]*8 +: 8], edat[k]); end
            end
            tick();
        end
    endtask

    // -----------------------------------------------------------------------
    // Scoreboard: each channel is a queue of words accepted but not yet
    // consumed. Occupancy, head data and in_ready all follow from it.
    task automatic test_random(input int which, input int n_words);
        int         nch   = (which == 2) ? 3 : 4;
        bit         rr    = (which == 1);
        logic [7:0] q [4][$];
        int         acc   = 0;
        int         drops = 0;
        int         sent  = 0;
        int         got   = 0;
        int         cyc   = 0;
        int         drain = 0;
        int         limit = n_words * 10 + 100;
        int         tgt;
        int         left;
        logic       exp_err = 1'b0;
        logic       exp_rdy;
        logic       exp_v;
        logic       accepted;
        dsel = which;
        apply_reset();
        while (drain < 3 && cyc < limit) begin
            if (!in_valid && sent < n_words && $urandom_range(0, 9) < 7) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                in_sel   = 2'($urandom_range(0, 3));
                sent++;
            end
            if (sent >= n_words && !in_valid) begin
                out_ready = 4'hF;
                drain++;
            end else begin
                out_ready = 4'($urandom);
            end
            #3;
            tgt     = rr ? (acc % nch) : int'(in_sel);
            exp_rdy = (tgt >= nch) || (q[tgt].size() == 0) || out_ready[tgt];
            n_chk++; if (c_rdy !== exp_rdy) begin n_fail++; $display("FAIL rand in_ready dut%0d cyc %0d: got %b expected %b", which, cyc, c_rdy, exp_rdy); end
            for (int i = 0; i < 4; i++) begin
                exp_v = (i < nch) && (q[i].size() != 0);
                n_chk++; if (c_val[i] !== exp_v) begin n_fail++; $display("FAIL rand out_valid[%0d] dut%0d cyc %0d: got %b expected %b", i, which, cyc, c_val[i], exp_v); end
                if (exp_v) begin
                    n_chk++; if (c_dat[i*8 +: 8] !== q[i][0]) begin n_fail++; $display("FAIL rand out_data[%0d] dut%0d cyc %0d: got %h expected %h", i, which, cyc, c_dat[i*8 +: 8], q[i][0]); end
                end
            end
            n_chk++; if (c_err !== exp_err) begin n_fail++; $display("FAIL rand drop_err dut%0d cyc %0d: got %b expected %b", which, cyc, c_err, exp_err); end
            n_chk++; if (c_cnt !== 8'((drops > 255) ? 255 : drops)) begin n_fail++; $display("FAIL rand drop_cnt dut%0d cyc %0d: got %0d expected %0d", which, cyc, c_cnt, (drops > 255) ? 255 : drops); end
            // Consumers take heads first, then the accepted word lands.
            for (int i = 0; i < nch; i++) begin
                if (q[i].size() != 0 && out_ready[i]) begin
                    void'(q[i].pop_front());
                    got++;
                end
            end
            exp_err  = 1'b0;
            accepted = in_valid && exp_rdy;
            if (accepted) begin
                if (tgt < nch) begin
                    q[tgt].push_back(in_data);
                    acc++;
                end else begin
                    drops++;
                    exp_err = 1'b1;
                end
            end
            tick();
            if (accepted) in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        n_chk++; if (cyc >= limit) begin n_fail++; $display("FAIL rand budget dut%0d: got %0d cycles expected fewer than %0d", which, cyc, limit); end
        left = q[0].size() + q[1].size() + q[2].size() + q[3].size();
        n_chk++; if (left != 0 || got != acc) begin n_fail++; $display("FAIL rand conservation dut%0d: got consumed %0d expected %0d (%0d left)", which, got, acc, left); end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before 5 ms");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sel    = 2'd0;
        out_ready = 4'hF;
        test_reset();
        test_addressed();
        test_stall();
        test_drop();
        test_async_reset();
        test_round_robin();
        test_random(0, 4000);
        test_random(1, 4000);
        test_random(2, 2000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
